rwt_axis_tag_escaper: RTL and testbench

//  AXI-Stream converter from "tag-bit" framing to "escaped" framing. Input tag words are

---
 rtl/rwt_axis_tag_escaper.sv | 161 ++++++++++++++++
 tb/tb_rwt_axis_tag_escaper.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwt_axis_tag_escaper.sv
//==============================================================================
//  Module      : rwt_axis_tag_escaper
//  Description : AXI-Stream converter from tuser tag-bit framing to in-band
//                escaped framing. Tag words are announced by a MAGIC word and
//                data words equal to MAGIC are sent as MAGIC followed by 0.
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rwt_axis_tag_escaper #(
   parameter int                 DWIDTH  = 32,
   parameter int                 UWIDTH  = 2,
   parameter int                 TAG_BIT = 1,
   parameter logic [DWIDTH-1:0]  MAGIC   = 32'hA5A5_5A5A
) (
   input  logic              m_clk,
   input  logic              m_resetn,
   // input stream (tag-bit framing)
   input  logic [DWIDTH-1:0] s_axis_tdata,
   input  logic [UWIDTH-1:0] s_axis_tuser,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   // output stream (escaped framing)
   output logic [DWIDTH-1:0] m_axis_tdata,
   output logic [UWIDTH-1:0] m_axis_tuser,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready
);

   // PASS: output register loaded straight from the input.
   // SECOND: output register holds the leading MAGIC, pending register holds
   //         the word that must follow it; input is stalled meanwhile.
   typedef enum logic [0:0] {
      ST_PASS   = 1'b0,
      ST_SECOND = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_in_esc;

   logic [DWIDTH-1:0] r_out_data;
   logic [UWIDTH-1:0] r_out_user;
   logic              r_out_last;
   logic              r_out_valid;

   logic [DWIDTH-1:0] r_pend_data;
   logic [UWIDTH-1:0] r_pend_user;
   logic              r_pend_last;

   logic              w_out_free;
   logic              w_accept;
   logic              w_is_tag;
   logic              w_tag_zero;
   logic              w_is_magic;
   logic              w_need_magic;
   logic              w_tag_more;

   // Input decode and handshake qualification
   always_comb begin
      w_out_free   = !r_out_valid || m_axis_tready;
      // Gated by reset so the input sees not-ready while reset is asserted
      s_axis_tready = m_resetn && w_out_free && (r_state == ST_PASS);
      w_accept     = s_axis_tvalid && s_axis_tready;
      w_is_tag     = s_axis_tuser[TAG_BIT];
      // A zero tag would decode downstream as escaped data, so it is dropped
      w_tag_zero   = w_is_tag && (s_axis_tdata == '0);
      w_is_magic   = !w_is_tag && (s_axis_tdata == MAGIC);
      // A MAGIC prefix is needed for a fresh tag chain or for literal MAGIC data
      w_need_magic = (w_is_tag && !w_tag_zero && !r_in_esc) || w_is_magic;
      w_tag_more   = s_axis_tdata[DWIDTH-1];
   end

   // State register
   always_ff @(posedge m_clk or negedge m_resetn) begin
      if (!m_resetn) begin
         r_state <= ST_PASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: enter SECOND on two-word sequences, leave once the
   // leading MAGIC has been taken by the sink
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_PASS: begin
            if (w_accept && w_need_magic) begin
               w_state_nxt = ST_SECOND;
            end
         end
         ST_SECOND: begin
            if (m_axis_tready) begin
               w_state_nxt = ST_PASS;
            end
         end
         default: w_state_nxt = ST_PASS;
      endcase
   end

   // Escape-chain flag: set only after a non-zero tag with its more bit set
   always_ff @(posedge m_clk or negedge m_resetn) begin
      if (!m_resetn) begin
         r_in_esc <= 1'b0;
      end else if (w_accept) begin
         r_in_esc <= w_is_tag && !w_tag_zero && w_tag_more;
      end
   end

   // Output and pending registers
   always_ff @(posedge m_clk or negedge m_resetn) begin
      if (!m_resetn) begin
         r_out_data  <= '0;
         r_out_user  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_pend_data <= '0;
         r_pend_user <= '0;
         r_pend_last <= 1'b0;
      end else if (r_state == ST_SECOND) begin
         if (m_axis_tready) begin
            r_out_data  <= r_pend_data;
            r_out_user  <= r_pend_user;
            r_out_last  <= r_pend_last;
            r_out_valid <= 1'b1;
         end
      end else if (w_accept) begin
         if (w_tag_zero) begin
            r_out_valid <= 1'b0;
         end else if (w_need_magic) begin
            r_out_data  <= MAGIC;
            r_out_user  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
            // Follower is the tag itself, or 0 standing for literal MAGIC data
            r_pend_data <= w_is_magic ? '0 : s_axis_tdata;
            r_pend_user <= w_is_magic ? s_axis_tuser : '0;
            r_pend_last <= s_axis_tlast;
         end else begin
            r_out_data  <= s_axis_tdata;
            r_out_user  <= w_is_tag ? '0 : s_axis_tuser;
            r_out_last  <= s_axis_tlast;
            r_out_valid <= 1'b1;
         end
      end else if (m_axis_tready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign m_axis_tdata  = r_out_data;
   assign m_axis_tuser  = r_out_user;
   assign m_axis_tlast  = r_out_last;
   assign m_axis_tvalid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rwt_axis_tag_escaper.sv
//==============================================================================
//  Module      : tb_rwt_axis_tag_escaper
//  Description : Directed self-checking bench for rwt_axis_tag_escaper.
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rwt_axis_tag_escaper;

   localparam logic [31:0] MAG = 32'hA5A5_5A5A;

   logic        m_clk = 1'b0;
   logic        m_resetn = 1'b0;
   logic [31:0] s_tdata = '0;
   logic [1:0]  s_tuser = '0;
   logic        s_tlast = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic [1:0]  m_tuser;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;
   bit tog_en = 1'b0;

   logic [31:0] q_d[$];
   logic [1:0]  q_u[$];
   logic        q_l[$];
   int          q_c[$];
   logic [31:0] e_d[$];
   logic [1:0]  e_u[$];
   logic        e_l[$];

   rwt_axis_tag_escaper #(
      .DWIDTH (32),
      .UWIDTH (2),
      .TAG_BIT(1),
      .MAGIC  (MAG)
   ) u_dut (
      .m_clk        (m_clk),
      .m_resetn     (m_resetn),
      .s_axis_tdata (s_tdata),
      .s_axis_tuser (s_tuser),
      .s_axis_tlast (s_tlast),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tuser (m_tuser),
      .m_axis_tlast (m_tlast),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready)
   );

   always #5 m_clk = ~m_clk;

   always @(posedge m_clk) cyc <= cyc + 1;

   // Record every output beat that will be transferred at the next rising edge
   always @(negedge m_clk) begin
      if (m_resetn && m_tvalid && m_tready) begin
         q_d.push_back(m_tdata);
         q_u.push_back(m_tuser);
         q_l.push_back(m_tlast);
         q_c.push_back(cyc);
      end
   end

   // Sink back-pressure pattern for the stall test
   initial begin
      forever begin
         @(posedge m_clk);
         #2;
         if (tog_en) m_tready = ~m_tready;
      end
   end

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] u, input logic l, input int gap);
      int t;
      repeat (gap) begin
         s_tvalid = 1'b0;
         @(posedge m_clk);
         #1;
      end
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      t = 0;
      @(negedge m_clk);
      while (!s_tready && t < 200) begin
         @(negedge m_clk);
         t++;
      end
      check_value("send_accept", {63'd0, s_tready}, 64'd1);
      last_acc_cyc = cyc;
      @(posedge m_clk);
      #1;
   endtask

   task automatic exp_beat(input logic [31:0] d, input logic [1:0] u, input logic l);
      e_d.push_back(d);
      e_u.push_back(u);
      e_l.push_back(l);
   endtask

   task automatic clear_q();
      q_d.delete(); q_u.delete(); q_l.delete(); q_c.delete();
      e_d.delete(); e_u.delete(); e_l.delete();
   endtask

   task automatic compare(input string name);
      int t;
      t = 0;
      while (q_d.size() < e_d.size() && t < 300) begin
         @(posedge m_clk);
         t++;
      end
      repeat (6) @(posedge m_clk);
      #1;
      check_value($sformatf("%s_count", name), 64'(q_d.size()), 64'(e_d.size()));
      for (int i = 0; i < e_d.size() && i < q_d.size(); i++) begin
         check_value($sformatf("%s_data%0d", name, i), {32'd0, q_d[i]}, {32'd0, e_d[i]});
         check_value($sformatf("%s_user%0d", name, i), {62'd0, q_u[i]}, {62'd0, e_u[i]});
         check_value($sformatf("%s_last%0d", name, i), {63'd0, q_l[i]}, {63'd0, e_l[i]});
      end
   endtask

   // Directed sequence
   initial begin
      int first_acc;
      repeat (3) @(posedge m_clk);
      #1;
      check_value("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
      check_value("rst_sready", {63'd0, s_tready}, 64'd0);
      check_value("rst_tdata",  {32'd0, m_tdata},  64'd0);
      check_value("rst_tuser",  {62'd0, m_tuser},  64'd0);
      check_value("rst_tlast",  {63'd0, m_tlast},  64'd0);
      m_resetn = 1'b1;
      @(posedge m_clk);
      #1;
      check_value("ready_after_rst", {63'd0, s_tready}, 64'd1);

      // plain data, full rate, 1-cycle latency
      clear_q();
      exp_beat(32'd1, 2'd0, 1'b0);
      exp_beat(32'd2, 2'd0, 1'b0);
      exp_beat(32'd3, 2'd0, 1'b1);
      send(32'd1, 2'd0, 1'b0, 0);
      first_acc = last_acc_cyc;
      send(32'd2, 2'd0, 1'b0, 0);
      send(32'd3, 2'd0, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("t1");
      if (q_c.size() >= 3) begin
         check_value("t1_latency", 64'(q_c[0] - first_acc), 64'd1);
         check_value("t1_rate",    64'(q_c[2] - q_c[0]),   64'd2);
      end

      // single tag then data
      clear_q();
      exp_beat(MAG,           2'd0, 1'b0);
      exp_beat(32'h0312_3456, 2'd0, 1'b0);
      exp_beat(32'd7,         2'd0, 1'b1);
      send(32'h0312_3456, 2'b10, 1'b0, 0);
      send(32'd7, 2'b00, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("t2");

      // chained tags share one MAGIC
      clear_q();
      exp_beat(MAG,           2'd0, 1'b0);
      exp_beat(32'h8100_0001, 2'd0, 1'b0);
      exp_beat(32'h0200_0002, 2'd0, 1'b0);
      exp_beat(32'd5,         2'd0, 1'b1);
      send(32'h8100_0001, 2'b10, 1'b0, 0);
      send(32'h0200_0002, 2'b10, 1'b0, 0);
      send(32'd5, 2'b00, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("t3");

      // literal MAGIC data
      clear_q();
      exp_beat(MAG,   2'd0, 1'b0);
      exp_beat(32'd0, 2'd1, 1'b1);
      send(MAG, 2'b01, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("t4");

      // zero tag dropped
      clear_q();
      exp_beat(32'd3, 2'd0, 1'b1);
      send(32'd0, 2'b10, 1'b0, 0);
      send(32'd3, 2'b00, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("tz");

      // zero tag ends an escape chain, so the next tag needs a fresh MAGIC
      clear_q();
      exp_beat(MAG,           2'd0, 1'b0);
      exp_beat(32'h8000_0009, 2'd0, 1'b0);
      exp_beat(MAG,           2'd0, 1'b0);
      exp_beat(32'h0100_0001, 2'd0, 1'b0);
      exp_beat(32'd4,         2'd0, 1'b1);
      send(32'h8000_0009, 2'b10, 1'b0, 0);
      send(32'd0,         2'b10, 1'b0, 0);
      send(32'h0100_0001, 2'b10, 1'b0, 0);
      send(32'd4,         2'b00, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("tc");

      // back-pressure and input gaps
      clear_q();
      tog_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_beat(MAG,           2'd0, 1'b0);
         exp_beat(32'h0312_3456, 2'd0, 1'b0);
         exp_beat(32'd7,         2'd0, 1'b1);
         send(32'h0312_3456, 2'b10, 1'b0, int'($urandom_range(0, 2)));
         send(32'd7, 2'b00, 1'b1, int'($urandom_range(0, 2)));
      end
      s_tvalid = 1'b0;
      compare("t5");
      tog_en = 1'b0;
      @(posedge m_clk);
      #3;
      m_tready = 1'b1;

      // reset in the middle of a MAGIC/tag pair
      clear_q();
      @(posedge m_clk);
      #1;
      m_tready = 1'b0;
      send(32'h0312_3456, 2'b10, 1'b0, 0);
      s_tvalid = 1'b0;
      @(posedge m_clk);
      #1;
      check_value("t6_held_valid", {63'd0, m_tvalid}, 64'd1);
      check_value("t6_held_data",  {32'd0, m_tdata},  {32'd0, MAG});
      check_value("t6_stall",      {63'd0, s_tready}, 64'd0);
      m_resetn = 1'b0;
      #1;
      check_value("t6_rst_valid", {63'd0, m_tvalid}, 64'd0);
      check_value("t6_rst_ready", {63'd0, s_tready}, 64'd0);
      repeat (2) @(posedge m_clk);
      #1;
      m_resetn = 1'b1;
      m_tready = 1'b1;
      clear_q();
      exp_beat(32'd9, 2'd0, 1'b1);
      send(32'd9, 2'b00, 1'b1, 0);
      s_tvalid = 1'b0;
      compare("t6");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
